// File: rtl/imem_boot_loader_if.sv
// Stream input and instruction-memory write bus of the boot loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready on the stream side; the write side has no backpressure.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  // Stream producer / instruction-memory side
  modport master (
    output in_data, in_valid,
    input  in_ready, im_we, im_addr, im_wdata
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian byte image into instruction memory; holds the CPU in reset until done.
// Latency: one im_we per 4 data bytes, one cycle after the 4th byte; cpu_rstn rises one cycle after the last write.
// Backpressure: in_ready low during the write cycle and in DONE/ERR; timeout aborts to ERR on a stalled stream.
module imem_boot_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rstn,
  imem_boot_loader_if.slave bus,
  input  logic              reload,
  output logic              cpu_rstn,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, WR, DONE, ERR} state_t;

  // Idle counter only needs to reach TIMEOUT-1; the next idle cycle trips the abort.
  localparam int                IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [16:0]       CAPACITY  = 17'(1) << ADDR_W;

  state_t            state;
  logic [15:0]       n;
  logic [1:0]        byte_idx;
  logic [23:0]       word_lo;
  logic [IDLE_W-1:0] idle;

  logic              accept;
  logic              timeout_hit;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   wl_next;
  logic              last_word;

  // Ready is a pure decode of the registered state, so it is high straight out of reset.
  assign bus.in_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept       = bus.in_valid && bus.in_ready;
  assign len_full     = {bus.in_data, n[7:0]};
  assign wl_next      = words_loaded + (ADDR_W + 1)'(1);
  assign last_word    = (32'(wl_next) == 32'(n));
  // LEN0 is excluded: the loader may wait forever for the first byte.
  assign timeout_hit  = (TIMEOUT != 0) && !accept && (idle == IDLE_LAST) &&
                        ((state == LEN1) || (state == DATA));

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= LEN0;
      n            <= '0;
      byte_idx     <= '0;
      word_lo      <= '0;
      idle         <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_rstn     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      bus.im_we <= 1'b0;
      case (state)
        LEN0: begin
          idle <= '0;
          if (accept) begin
            n[7:0] <= bus.in_data;
            state  <= LEN1;
          end
        end

        LEN1: begin
          if (accept) begin
            idle    <= '0;
            n[15:8] <= bus.in_data;
            if (len_full == 16'd0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_rstn <= 1'b1;
            end else if ({1'b0, len_full} > CAPACITY) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end else if (timeout_hit) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            idle <= idle + IDLE_W'(1);
          end
        end

        DATA: begin
          if (accept) begin
            idle     <= '0;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= bus.in_data;
              2'd1: word_lo[15:8]  <= bus.in_data;
              2'd2: word_lo[23:16] <= bus.in_data;
              default: begin
                // 4th byte completes the word; issue the write next cycle.
                bus.im_we    <= 1'b1;
                bus.im_addr  <= words_loaded[ADDR_W-1:0];
                bus.im_wdata <= {bus.in_data, word_lo};
                state        <= WR;
              end
            endcase
          end else if (timeout_hit) begin
            state <= ERR;
            err   <= 1'b1;
          end else if (TIMEOUT != 0) begin
            idle <= idle + IDLE_W'(1);
          end
        end

        WR: begin
          words_loaded <= wl_next;
          if (last_word) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_rstn <= 1'b1;
          end else begin
            state <= DATA;
          end
        end

        DONE, ERR: begin
          if (reload) begin
            state        <= LEN0;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_rstn     <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            idle         <= '0;
          end
        end

        default: state <= LEN0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader with a queue-based image model.
// Latency: n/a.
// Backpressure: stream driver honours in_ready with bounded waits.
module tb_imem_boot_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              reload;
  logic              cpu_rstn;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .reload       (reload),
    .cpu_rstn     (cpu_rstn),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  wr_t         exp_q[$];
  int          exp_n  = 0;
  bit          exp_err = 0;
  int          wl_model = 0;
  logic [31:0] mem [0:255];
  int          cyc = 0;
  int          last_we = 0;
  logic        done_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Per-cycle comparison of the write bus and status against the image model.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    chk("words_loaded", words_loaded, wl_model);
    chk("cpu_rstn_eq_done", cpu_rstn, done);
    chk("err_done_excl", err & done, 0);
    if (bus.im_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", bus.im_we, 0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", bus.im_addr, e.addr);
        chk("we_data", bus.im_wdata, e.data);
        mem[bus.im_addr] = bus.im_wdata;
        last_we = cyc;
        wl_model++;
      end
    end
    if (done && !done_q && exp_n != 0) chk("done_latency", cyc - last_we, 1);
    done_q = done;
  end

  // Expected writes straight from the image: length prefix then little-endian words.
  task automatic build_model(input logic [7:0] q[$]);
    exp_n   = {q[1], q[0]};
    exp_err = (exp_n > 256);
    exp_q.delete();
    if (!exp_err) begin
      for (int i = 0; i < exp_n; i++) begin
        wr_t w;
        w.addr = i;
        w.data = {q[4*i+5], q[4*i+4], q[4*i+3], q[4*i+2]};
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    got = 0;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) chk("byte_accept", bus.in_ready, 1);
  endtask

  task automatic finish_check(output int waited);
    waited = 0;
    while (!(done || err) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("end_done", done, !exp_err);
    chk("end_err", err, exp_err);
    chk("end_cpu_rstn", cpu_rstn, !exp_err);
    chk("end_ready", bus.in_ready, 0);
    chk("pending_writes", exp_q.size(), 0);
    if (!exp_err) chk("end_words", words_loaded, exp_n);
  endtask

  task automatic run_stream(input logic [7:0] q[$], input int maxgap, output int waited);
    build_model(q);
    foreach (q[i]) send_byte(q[i], $urandom_range(0, maxgap));
    finish_check(waited);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload   = 1'b0;
    wl_model = 0;
    exp_q.delete();
    chk("reload_ready", bus.in_ready, 1);
    chk("reload_done", done, 0);
    chk("reload_err", err, 0);
    chk("reload_cpu_rstn", cpu_rstn, 0);
  endtask

  task automatic check_reset_values();
    chk("rst_im_we", bus.im_we, 0);
    chk("rst_im_addr", bus.im_addr, 0);
    chk("rst_im_wdata", bus.im_wdata, 0);
    chk("rst_cpu_rstn", cpu_rstn, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_ready", bus.in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int waited;
    int e;

    rstn = 1'b0;
    reload = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rstn = 1'b1;
    @(posedge clk); #1;

    // Two-word image with literal expectations
    q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};
    run_stream(q, 0, waited);
    chk("t1_done_delay", waited, 1);
    chk("t1_mem0", mem[0], 32'h00500513);
    chk("t1_mem1", mem[1], 32'h00a00593);
    chk("t1_words", words_loaded, 2);
    do_reload();

    // Empty image
    q = '{8'h00, 8'h00};
    run_stream(q, 2, waited);
    chk("t2_done_delay", waited, 0);
    do_reload();

    // Oversized image -> ERR, then reload while a byte is offered
    q = '{8'h01, 8'h01};
    run_stream(q, 2, waited);
    chk("t3_err_delay", waited, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    reload = 1'b1;
    @(negedge clk);
    chk("t3_ready_during_reload", bus.in_ready, 0);
    @(posedge clk); #1;
    reload = 1'b0;
    bus.in_valid = 1'b0;
    wl_model = 0;
    exp_q.delete();
    chk("t3_ready_after_reload", bus.in_ready, 1);
    chk("t3_err_after_reload", err, 0);

    // Timeout: stall after the first data byte
    exp_n = 0;
    exp_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'haa, 0);
    e = 0;
    while (!err && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    chk("t4_timeout_edges", e, 16);
    chk("t4_err", err, 1);
    chk("t4_cpu_rstn", cpu_rstn, 0);
    chk("t4_ready", bus.in_ready, 0);
    do_reload();

    // Valid toggling, with one 15-cycle gap just under the timeout
    q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    build_model(q);
    foreach (q[i]) send_byte(q[i], (i == 4) ? 15 : 1);
    finish_check(waited);
    chk("t5_mem0", mem[0], 32'h44332211);
    do_reload();

    // Reset in the middle of DATA after two of four words
    q = '{8'h04, 8'h00};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom_range(0, 255)));
    build_model(q);
    for (int i = 0; i < 10; i++) send_byte(q[i], 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("t6_words_before_rst", words_loaded, 2);
    rstn = 1'b0;
    wl_model = 0;
    exp_q.delete();
    #1;
    check_reset_values();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    q = '{8'h02, 8'h00};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom_range(0, 255)));
    run_stream(q, 3, waited);
    do_reload();

    // Full-capacity image with random gaps, then an extra byte
    q = '{8'h00, 8'h01};
    for (int i = 0; i < 1024; i++) q.push_back(8'($urandom_range(0, 255)));
    run_stream(q, 4, waited);
    chk("t7_words", words_loaded, 256);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5a;
    repeat (5) begin
      @(negedge clk);
      chk("t7_extra_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t7_words_after_extra", words_loaded, 256);
    chk("t7_done_after_extra", done, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
